// File: rtl/btn_event_reader.sv
// Push-button front end: 2-flop sync, per-button debounce, press/release/long-press
// pulses and a one-at-a-time valid/ready event port. Long-press logic gated by BTN_LONG_PRESS_EN.
module btn_event_reader #(
  parameter int N_BTN       = 2,
  parameter int DEB_CYCLES  = 2000000,
  parameter int LONG_CYCLES = 200000000,
  parameter int IDX_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             per_reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_type,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_overflow
);

  localparam logic [31:0] DEB_LAST = 32'(DEB_CYCLES - 1);

  localparam logic [1:0] T_PRESS   = 2'b01;
  localparam logic [1:0] T_RELEASE = 2'b10;
  localparam logic [1:0] T_LONG    = 2'b11;

  logic [N_BTN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge per_reset) begin
    if (per_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [31:0] dc_q;
      logic        level_q, press_q, rel_q;

      always_ff @(posedge clk or posedge per_reset) begin
        if (per_reset) begin
          dc_q    <= '0;
          level_q <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
        end else begin
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          if (sync2_q[gi] == level_q) begin
            dc_q <= '0;
          end else if (dc_q == DEB_LAST) begin
            // Pulses land in the same cycle the new level becomes visible
            level_q <= sync2_q[gi];
            press_q <= sync2_q[gi];
            rel_q   <= ~sync2_q[gi];
            dc_q    <= '0;
          end else begin
            dc_q <= dc_q + 32'd1;
          end
        end
      end

      assign btn_level[gi]     = level_q;
      assign press_pulse[gi]   = press_q;
      assign release_pulse[gi] = rel_q;

`ifdef BTN_LONG_PRESS_EN
      localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
      localparam logic [31:0] LONG_MAX  = 32'(LONG_CYCLES);
      logic [31:0] hc_q;
      logic        long_q;

      // Saturating at LONG_MAX makes the LONG_LAST match happen once per press
      always_ff @(posedge clk or posedge per_reset) begin
        if (per_reset) begin
          hc_q   <= '0;
          long_q <= 1'b0;
        end else begin
          long_q <= level_q && (hc_q == LONG_LAST);
          if (!level_q)
            hc_q <= '0;
          else if (hc_q != LONG_MAX)
            hc_q <= hc_q + 32'd1;
        end
      end

      assign long_pulse[gi] = long_q;
`else
      assign long_pulse[gi] = 1'b0;
`endif
    end
  endgenerate

  logic [N_BTN-1:0] pend_press_q, pend_press_d;
  logic [N_BTN-1:0] pend_rel_q, pend_rel_d;
  logic [N_BTN-1:0] pend_long_q;
  logic [N_BTN-1:0] clr_press, clr_rel, clr_long;
  logic [N_BTN-1:0] sel_oh;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [1:0]       sel_type;
  logic             load;
  logic             ovf_set;
  logic             evt_valid_q;
  logic [1:0]       evt_type_q;
  logic [IDX_W-1:0] evt_idx_q;
  logic             evt_overflow_q;

  assign load = !evt_valid_q || evt_ready;

  // Descending scan so the lowest pending button index wins
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_type  = 2'b00;
    sel_oh    = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_press_q[i] || pend_long_q[i] || pend_rel_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        if (pend_press_q[i])
          sel_type = T_PRESS;
        else if (pend_long_q[i])
          sel_type = T_LONG;
        else
          sel_type = T_RELEASE;
      end
    end
  end

  always_comb begin
    clr_press = '0;
    clr_rel   = '0;
    clr_long  = '0;
    if (load && sel_found) begin
      case (sel_type)
        T_PRESS: clr_press = sel_oh;
        T_LONG:  clr_long  = sel_oh;
        default: clr_rel   = sel_oh;
      endcase
    end
  end

  // A pulse only overflows if its bit stays occupied; a coinciding clear frees the slot
  assign pend_press_d = (pend_press_q & ~clr_press) | press_pulse;
  assign pend_rel_d   = (pend_rel_q & ~clr_rel) | release_pulse;
  assign ovf_set = |(press_pulse & pend_press_q & ~clr_press)
                 | |(release_pulse & pend_rel_q & ~clr_rel)
                 | |(long_pulse & pend_long_q & ~clr_long);

`ifdef BTN_LONG_PRESS_EN
  logic [N_BTN-1:0] pend_long_d;
  assign pend_long_d = (pend_long_q & ~clr_long) | long_pulse;

  always_ff @(posedge clk or posedge per_reset) begin
    if (per_reset)
      pend_long_q <= '0;
    else
      pend_long_q <= pend_long_d;
  end
`else
  assign pend_long_q = '0;
`endif

  always_ff @(posedge clk or posedge per_reset) begin
    if (per_reset) begin
      pend_press_q   <= '0;
      pend_rel_q     <= '0;
      evt_valid_q    <= 1'b0;
      evt_type_q     <= 2'b00;
      evt_idx_q      <= '0;
      evt_overflow_q <= 1'b0;
    end else begin
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      if (ovf_set)
        evt_overflow_q <= 1'b1;
      if (load) begin
        evt_valid_q <= sel_found;
        evt_type_q  <= sel_type;
        evt_idx_q   <= sel_idx;
      end
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_type     = evt_type_q;
  assign evt_idx      = evt_idx_q;
  assign evt_overflow = evt_overflow_q;

endmodule

// File: tb/tb_btn_event_reader.sv
// Directed bench for btn_event_reader with a scoreboard of expected events,
// popped and compared whenever the DUT completes a handshake.
module tb_btn_event_reader;

  localparam int N_BTN = 2;
  localparam int DEB   = 8;
  localparam int LONG  = 40;

  logic       clk = 1'b0;
  logic       per_reset;
  logic [1:0] btn_in;
  logic [1:0] btn_level, press_pulse, release_pulse, long_pulse;
  logic       evt_valid, evt_ready;
  logic [1:0] evt_type;
  logic [0:0] evt_idx;
  logic       evt_overflow;

  btn_event_reader #(
    .N_BTN(N_BTN), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .per_reset(per_reset), .btn_in(btn_in),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_type(evt_type), .evt_idx(evt_idx), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] t;
    logic [0:0] i;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] t, input logic [0:0] i);
    evt_t e;
    e.t = t;
    e.i = i;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    bit done = 1'b0;
    for (int c = 0; c < bound && !done; c++) begin
      step(1);
      if (exp_q.size() == 0 && !evt_valid)
        done = 1'b1;
    end
    check({tag, "_idle"}, {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: every completed handshake must match the oldest expected event
  always @(negedge clk) begin
    evt_t e;
    if (!per_reset && evt_valid && evt_ready) begin
      $display("evt type=%b idx=%0d overflow=%b t=%0t", evt_type, evt_idx, evt_overflow, $time);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_evt: observed type=%b idx=%0d expected none", evt_type, evt_idx);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({evt_type, evt_idx} === {e.t, e.i}) else begin
          errors++;
          $error("FAIL evt: observed type=%b idx=%0d expected type=%b idx=%0d",
                 evt_type, evt_idx, e.t, e.i);
        end
      end
    end
  end

  initial begin
    int p_cyc, l_cyc, n_long;
    bit got;

    per_reset = 1'b1;
    btn_in    = 2'b00;
    evt_ready = 1'b1;
    step(3);
    check("reset_state", {btn_level, press_pulse, release_pulse, long_pulse,
                          evt_valid, evt_type, evt_idx, evt_overflow}, 32'd0);
    per_reset = 1'b0;
    step(2);

    // Glitch: 7 high samples is one short of the debounce threshold
    btn_in = 2'b01;
    step(7);
    btn_in = 2'b00;
    for (int c = 0; c < 20; c++) begin
      step(1);
      check("glitch_quiet", {btn_level, press_pulse, evt_valid}, 32'd0);
    end

    // Clean press with cycle-exact latency
    btn_in = 2'b01;
    push(2'b01, 1'b0);
    step(9);
    check("press_level_e9", btn_level, 32'd0);
    step(1);
    check("press_level_e10", btn_level, 32'd1);
    check("press_pulse_e10", press_pulse, 32'd1);
    step(1);
    check("press_pulse_e11", press_pulse, 32'd0);
    check("press_valid_e11", evt_valid, 32'd0);
    step(1);
    check("press_evt_e12", {evt_valid, evt_type, evt_idx}, {28'd0, 1'b1, 2'b01, 1'b0});
    btn_in = 2'b00;
    push(2'b10, 1'b0);
    wait_idle("clean", 40);

    // Long press on button 1
    btn_in = 2'b10;
    push(2'b01, 1'b1);
`ifdef BTN_LONG_PRESS_EN
    push(2'b11, 1'b1);
`endif
    push(2'b10, 1'b1);
    p_cyc = -1;
    l_cyc = -1;
    n_long = 0;
    for (int c = 1; c <= 60; c++) begin
      step(1);
      if (press_pulse[1]) p_cyc = c;
      if (long_pulse[1]) begin
        l_cyc = c;
        n_long++;
      end
    end
    btn_in = 2'b00;
    check("long_press_seen", p_cyc, 32'd10);
`ifdef BTN_LONG_PRESS_EN
    check("long_delay", l_cyc - p_cyc, LONG);
    check("long_count", n_long, 32'd1);
`else
    check("long_count", n_long, 32'd0);
`endif
    wait_idle("long", 60);

    // Simultaneous rise: index 0 first, index 1 on the next cycle
    btn_in = 2'b11;
    push(2'b01, 1'b0);
    push(2'b01, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      step(1);
      got = evt_valid;
    end
    check("simul_first", {got, evt_type, evt_idx}, {28'd0, 1'b1, 2'b01, 1'b0});
    step(1);
    check("simul_second", {evt_valid, evt_type, evt_idx}, {28'd0, 1'b1, 2'b01, 1'b1});
    btn_in = 2'b00;
    push(2'b10, 1'b0);
    push(2'b10, 1'b1);
    wait_idle("simul", 40);

    // Backpressure: second release collides with the still-pending first release
    evt_ready = 1'b0;
    btn_in = 2'b01;
    push(2'b01, 1'b0);
    step(14);
    check("bp_hold1", {evt_valid, evt_type, evt_idx}, {28'd0, 1'b1, 2'b01, 1'b0});
    btn_in = 2'b00;
    push(2'b01, 1'b0);
    push(2'b10, 1'b0);
    step(14);
    btn_in = 2'b01;
    step(14);
    check("bp_no_ovf_yet", evt_overflow, 32'd0);
    btn_in = 2'b00;
    step(14);
    check("bp_hold2", {evt_valid, evt_type, evt_idx}, {28'd0, 1'b1, 2'b01, 1'b0});
    check("bp_overflow", evt_overflow, 32'd1);
    evt_ready = 1'b1;
    wait_idle("bp", 20);
    check("bp_overflow_sticky", evt_overflow, 32'd1);

    // Reset while an event is held and the button is down
    evt_ready = 1'b0;
    btn_in = 2'b01;
    step(14);
    check("rst_pre_valid", {evt_valid, btn_level}, {29'd0, 1'b1, 2'b01});
    per_reset = 1'b1;
    #1;
    check("rst_async", {btn_level, press_pulse, release_pulse, long_pulse,
                        evt_valid, evt_type, evt_idx, evt_overflow}, 32'd0);
    step(3);
    check("rst_held", {btn_level, press_pulse, release_pulse, long_pulse,
                       evt_valid, evt_type, evt_idx, evt_overflow}, 32'd0);
    per_reset = 1'b0;
    evt_ready = 1'b1;
    push(2'b01, 1'b0);
    p_cyc = -1;
    for (int c = 1; c <= 20 && p_cyc < 0; c++) begin
      step(1);
      if (press_pulse[0]) p_cyc = c;
    end
    check("rst_repress_delay", p_cyc, 32'd10);
    wait_idle("rst_press", 10);
    btn_in = 2'b00;
    push(2'b10, 1'b0);
    wait_idle("rst_release", 40);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
